// File: rtl/fir_pkg.sv
// Shared defaults, derived widths and FSM state encoding for the
// time-multiplexed FIR MAC scheduler.
package fir_pkg;

  localparam int DEF_N_TAPS  = 6;
  localparam int DEF_BW_IN   = 6;
  localparam int DEF_BW_COEF = 6;
  localparam int DEF_BW_OUT  = 8;
  localparam int DEF_SHIFT   = 5;

  // Accumulator must hold N_TAPS full-precision products without overflow.
  function automatic int acc_width(input int bw_in, input int bw_coef, input int n_taps);
    return bw_in + bw_coef + $clog2(n_taps);
  endfunction

  localparam int DEF_BW_ACC = acc_width(DEF_BW_IN, DEF_BW_COEF, DEF_N_TAPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MAC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_sat.sv
// Arithmetic right shift of the accumulator followed by saturation to the
// signed output range. Purely combinational.
module fir_sat
  import fir_pkg::*;
#(
  parameter int BW_acc = DEF_BW_ACC,
  parameter int BW_out = DEF_BW_OUT,
  parameter int SHIFT  = DEF_SHIFT
) (
  input  logic signed [BW_acc-1:0] acc_in,
  output logic signed [BW_out-1:0] y_out
);

  localparam logic signed [BW_acc-1:0] Y_MAX =
    {{(BW_acc-BW_out+1){1'b0}}, {(BW_out-1){1'b1}}};
  localparam logic signed [BW_acc-1:0] Y_MIN =
    {{(BW_acc-BW_out+1){1'b1}}, {(BW_out-1){1'b0}}};

  logic signed [BW_acc-1:0] shifted;

  always_comb begin
    shifted = acc_in >>> SHIFT;
    if (shifted > Y_MAX) begin
      y_out = Y_MAX[BW_out-1:0];
    end else if (shifted < Y_MIN) begin
      y_out = Y_MIN[BW_out-1:0];
    end else begin
      y_out = shifted[BW_out-1:0];
    end
  end

endmodule

// File: rtl/fir_mac_scheduler.sv
// FIR filter sharing one multiplier and one accumulator across all taps:
// accept a sample in IDLE, one tap per cycle in MAC, hold the result in OUT.
module fir_mac_scheduler
  import fir_pkg::*;
#(
  parameter int N_TAPS  = DEF_N_TAPS,
  parameter int BW_in   = DEF_BW_IN,
  parameter int BW_coef = DEF_BW_COEF,
  parameter int BW_out  = DEF_BW_OUT,
  parameter int SHIFT   = DEF_SHIFT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [BW_in-1:0]   x_in,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic signed [BW_out-1:0]  y_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic                      cfg_we,
  input  logic [$clog2(N_TAPS)-1:0] cfg_addr,
  input  logic signed [BW_coef-1:0] cfg_data,
  output logic                      busy
);

  localparam int AW      = $clog2(N_TAPS);
  localparam int BW_ACC  = acc_width(BW_in, BW_coef, N_TAPS);
  localparam int BW_PROD = BW_in + BW_coef;
  localparam logic [AW-1:0] K_LAST = AW'(N_TAPS - 1);

  state_t                    state_q, state_d;
  logic [AW-1:0]             k_q, k_d;
  logic signed [BW_ACC-1:0]  acc_q, acc_d, acc_sum;
  logic signed [BW_in-1:0]   d_q    [N_TAPS];
  logic signed [BW_in-1:0]   d_d    [N_TAPS];
  logic signed [BW_coef-1:0] coef_q [N_TAPS];
  logic signed [BW_coef-1:0] coef_d [N_TAPS];
  logic signed [BW_out-1:0]  y_q, y_d, y_sat;
  logic                      out_valid_q, out_valid_d;
  logic signed [BW_PROD-1:0] prod;

  assign prod    = BW_PROD'(coef_q[k_q]) * BW_PROD'(d_q[k_q]);
  assign acc_sum = acc_q + BW_ACC'(prod);

  // Saturate the sum including the last tap, so y_out is registered on the
  // same edge that enters OUT and no extra pipeline state is needed.
  fir_sat #(
    .BW_acc(BW_ACC),
    .BW_out(BW_out),
    .SHIFT (SHIFT)
  ) u_sat (
    .acc_in(acc_sum),
    .y_out (y_sat)
  );

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    acc_d       = acc_q;
    d_d         = d_q;
    coef_d      = coef_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (cfg_we && (int'(cfg_addr) < N_TAPS)) begin
          coef_d[cfg_addr] = cfg_data;
        end
        if (in_valid) begin
          for (int unsigned i = 1; i < N_TAPS; i++) begin
            d_d[i] = d_q[i-1];
          end
          d_d[0]  = x_in;
          acc_d   = '0;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        k_d   = k_q + AW'(1);
        if (k_q == K_LAST) begin
          k_d         = '0;
          y_d         = y_sat;
          out_valid_d = 1'b1;
          state_d     = S_OUT;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      out_valid_q <= 1'b0;
      for (int unsigned i = 0; i < N_TAPS; i++) begin
        d_q[i]    <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      d_q         <= d_d;
      coef_q      <= coef_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign y_out     = y_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Self-checking bench: two scheduler instances (SHIFT=0 and SHIFT=5) share
// stimulus and are compared against a sum-of-products reference model.
module tb_fir_mac_scheduler;

  localparam int N       = 6;
  localparam int BW_IN   = 6;
  localparam int BW_COEF = 6;
  localparam int BW_OUT  = 8;
  localparam int AW      = $clog2(N);
  localparam int Y_MAX   = (2 ** (BW_OUT - 1)) - 1;
  localparam int Y_MIN   = -(2 ** (BW_OUT - 1));

  logic                      clk;
  logic                      rst;
  logic signed [BW_IN-1:0]   x_in;
  logic                      in_valid;
  logic                      out_ready;
  logic                      cfg_we;
  logic [AW-1:0]             cfg_addr;
  logic signed [BW_COEF-1:0] cfg_data;
  logic                      in_ready0, out_valid0, busy0;
  logic                      in_ready5, out_valid5, busy5;
  logic signed [BW_OUT-1:0]  y0, y5;

  int coef_m [N];
  int dl_m   [N];
  int n_assert = 0;
  int n_fail   = 0;

  fir_mac_scheduler #(
    .N_TAPS(N), .BW_in(BW_IN), .BW_coef(BW_COEF), .BW_out(BW_OUT), .SHIFT(0)
  ) dut_s0 (
    .clk(clk), .rst(rst), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready0),
    .y_out(y0), .out_valid(out_valid0), .out_ready(out_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy0)
  );

  fir_mac_scheduler #(
    .N_TAPS(N), .BW_in(BW_IN), .BW_coef(BW_COEF), .BW_out(BW_OUT), .SHIFT(5)
  ) dut_s5 (
    .clk(clk), .rst(rst), .x_in(x_in), .in_valid(in_valid), .in_ready(in_ready5),
    .y_out(y5), .out_valid(out_valid5), .out_ready(out_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .busy(busy5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_y(input int sh);
    int acc;
    int y;
    acc = 0;
    for (int i = 0; i < N; i++) acc += coef_m[i] * dl_m[i];
    y = acc >>> sh;
    if (y > Y_MAX) y = Y_MAX;
    if (y < Y_MIN) y = Y_MIN;
    return y;
  endfunction

  task automatic wr(input int a, input int v);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_data = BW_COEF'(v);
    @(posedge clk);
    if (a < N) coef_m[a] = v;
    #1 cfg_we = 1'b0;
  endtask

  task automatic send(input int x, input int hold, input bit acc_we, input int ca,
                      input int cd, input bit mac_we, output int r0, output int r5);
    int cyc;
    logic signed [BW_OUT-1:0] h0, h5;
    @(negedge clk);
    x_in      = BW_IN'(x);
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    cfg_we    = acc_we;
    cfg_addr  = AW'(ca);
    cfg_data  = BW_COEF'(cd);
    @(posedge clk);
    if (acc_we && ca < N) coef_m[ca] = cd;
    for (int i = N - 1; i > 0; i--) dl_m[i] = dl_m[i-1];
    dl_m[0] = x;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      in_valid = 1'($urandom_range(0, 1));
      x_in     = BW_IN'($urandom);
      cfg_we   = mac_we && (cyc == 2);
      cfg_addr = '0;
      cfg_data = BW_COEF'(7);
      if (cyc == 1) begin
        chk("busy_in_mac", busy0, 1);
        chk("in_ready_in_mac", in_ready5, 0);
      end
    end while (out_valid0 !== 1'b1 && cyc < 40);
    cfg_we = 1'b0;
    chk("latency", cyc, N + 1);
    chk("out_valid_s5", out_valid5, 1);
    chk("y_shift0", y0, model_y(0));
    chk("y_shift5", y5, model_y(5));
    chk("in_ready_in_out", in_ready0, 0);
    h0 = y0;
    h5 = y5;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = BW_IN'($urandom);
      chk("hold_out_valid", out_valid0, 1);
      chk("hold_y", y0, h0);
      chk("hold_in_ready", in_ready0, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("exit_out_valid", out_valid0, 0);
    chk("exit_in_ready", in_ready5, 1);
    chk("exit_busy", busy0, 0);
    chk("y_retained", y5, h5);
    r0 = h0;
    r5 = h5;
  endtask

  initial begin
    int r0, r5;
    bit seen_ov;
    rst       = 1'b1;
    x_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_data  = '0;
    for (int i = 0; i < N; i++) begin
      coef_m[i] = 0;
      dl_m[i]   = 0;
    end
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_busy_s5", busy5, 0);
    chk("rst_in_ready", in_ready0, 1);
    chk("rst_y_s0", y0, 0);
    chk("rst_y_s5", y5, 0);

    // release mid-cycle so the very next edge carries a sample plus a write
    @(posedge clk);
    #2 rst = 1'b1;
    send(5, 0, 1'b1, 0, 1, 1'b0, r0, r5);
    chk("first_edge_accept", r0, 5);

    for (int i = 0; i < N; i++) wr(i, i + 1);
    wr(6, -1);
    wr(7, -1);
    send(-3, 0, 1'b0, 0, 0, 1'b0, r0, r5);

    for (int i = 0; i < N; i++) wr(i, 31);
    repeat (N) send(31, 0, 1'b0, 0, 0, 1'b0, r0, r5);
    chk("sat_pos_s0", r0, 127);
    chk("sat_pos_s5", r5, 127);
    repeat (N) send(-32, 0, 1'b0, 0, 0, 1'b0, r0, r5);
    chk("sat_neg_s0", r0, -128);
    chk("sat_neg_s5", r5, -128);

    send(int'($urandom_range(0, 63)) - 32, 5, 1'b0, 0, 0, 1'b0, r0, r5);

    send(int'($urandom_range(0, 63)) - 32, 0, 1'b0, 0, 0, 1'b1, r0, r5);
    send(int'($urandom_range(0, 63)) - 32, 0, 1'b0, 0, 0, 1'b0, r0, r5);
    send(int'($urandom_range(0, 63)) - 32, 0, 1'b1, 0, 7, 1'b0, r0, r5);

    for (int i = 0; i < N; i++) wr(i, int'($urandom_range(0, 63)) - 32);
    for (int t = 0; t < 10; t++) begin
      send(int'($urandom_range(0, 63)) - 32, int'($urandom_range(0, 2)),
           1'b0, 0, 0, 1'b0, r0, r5);
    end

    // abort a computation three taps in
    @(negedge clk);
    x_in     = BW_IN'(3);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_out_valid", out_valid0, 0);
    chk("abort_busy", busy0, 0);
    chk("abort_in_ready", in_ready5, 1);
    chk("abort_y", y0, 0);
    for (int i = 0; i < N; i++) begin
      coef_m[i] = 0;
      dl_m[i]   = 0;
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    seen_ov = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid0 !== 1'b0 || out_valid5 !== 1'b0) seen_ov = 1'b1;
    end
    chk("no_out_valid_after_abort", seen_ov, 0);

    for (int i = 0; i < N; i++) wr(i, i + 1);
    send(1, 0, 1'b0, 0, 0, 1'b0, r0, r5);
    chk("impulse_tap0", r0, 1);
    for (int k = 1; k < N; k++) begin
      send(0, 0, 1'b0, 0, 0, 1'b0, r0, r5);
      chk("impulse_tap", r0, k + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
